// File: rtl/seq_mul.sv
// Multi-cycle shift-add unsigned multiplier: one partial product per clock,
// fixed WIDTH+1 cycle latency, truncated product plus an overflow flag.
//
// state  | meaning
// S_IDLE | waiting for Start
// S_RUN  | WIDTH shift-add steps in progress
// S_DONE | one-cycle result pulse; Start here begins the next operation
module seq_mul #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Prod,
    output logic             Ovf,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic               accept;
    logic               last_step;

    assign accept    = Start && ((state == S_IDLE) || (state == S_DONE));
    assign last_step = (state == S_RUN) && (count == LAST_STEP);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = Start ? S_RUN : S_IDLE;
            S_RUN:   state_next = last_step ? S_DONE : S_RUN;
            S_DONE:  state_next = Start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        case (state)
            S_RUN:   Busy = 1'b1;
            S_DONE:  Done = 1'b1;
            default: begin
                Busy = 1'b0;
                Done = 1'b0;
            end
        endcase
    end

    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    // Prod/Ovf load only on the final step, so they hold until the next result.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            Prod   <= '0;
            Ovf    <= 1'b0;
        end else begin
            if (accept) begin
                mcand  <= {{WIDTH{1'b0}}, A};
                mplier <= B;
                acc    <= '0;
                count  <= '0;
            end else if (state == S_RUN) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + 1'b1;
            end
            if (last_step) begin
                Prod <= acc_next[WIDTH-1:0];
                Ovf  <= |acc_next[2*WIDTH-1:WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
// Bench for seq_mul: scoreboard of expected products checked against every Done,
// plus targeted checks of busy timing, restart, abort and a WIDTH=4 instance.
module tb_seq_mul;

    typedef struct {
        logic [15:0] prod;
        logic        ovf;
        int          edge_no;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [15:0] prod;
    logic        ovf, busy, done;

    logic        start4 = 1'b0;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic [3:0]  prod4;
    logic        ovf4, busy4, done4;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   dones = 0;
    exp_t sb[$];

    seq_mul #(.WIDTH(16)) dut (
        .Clk(clk), .Rst(rst), .Start(start), .A(a), .B(b),
        .Prod(prod), .Ovf(ovf), .Busy(busy), .Done(done)
    );

    seq_mul #(.WIDTH(4)) dut4 (
        .Clk(clk), .Rst(rst), .Start(start4), .A(a4), .B(b4),
        .Prod(prod4), .Ovf(ovf4), .Busy(busy4), .Done(done4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Each Done must match the oldest outstanding request, on its exact edge.
    always @(negedge clk) begin
        if (!rst && done) begin
            dones++;
            chk("done_has_request", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("prod", prod, e.prod);
                chk("ovf", ovf, e.ovf);
                chk("latency", cyc, e.edge_no);
            end
        end
    end

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input int acc_edge);
        logic [31:0] p;
        exp_t e;
        p = 32'(x) * 32'(y);
        e.prod = p[15:0];
        e.ovf = (p[31:16] != 16'd0);
        e.edge_no = acc_edge + 16;
        return e;
    endfunction

    // Returns #1 after the accept edge.
    task automatic issue(input logic [15:0] x, input logic [15:0] y);
        @(posedge clk); #1;
        start = 1'b1; a = x; b = y;
        sb.push_back(model(x, y, cyc + 1));
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int d0, n;
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, n;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_prod", prod, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // Busy for exactly 16 cycles, then a single Done, then the result holds.
        issue(16'd64, 16'd8);
        for (int i = 0; i < 16; i++) begin
            chk("t1_busy", busy, 1);
            @(posedge clk); #1;
        end
        chk("t1_done", done, 1);
        chk("t1_busy_off", busy, 0);
        @(posedge clk); #1;
        chk("t1_done_off", done, 0);
        chk("t1_hold", prod, 512);
        drain(5);

        issue(16'd300, 16'd300);
        drain(30);
        issue(16'd65535, 16'd65535);
        drain(30);
        issue(16'd0, 16'd12345);
        drain(30);
        issue(16'd1234, 16'd53);
        drain(30);

        // Start during RUN is ignored.
        d0 = dones;
        issue(16'd7, 16'd9);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; a = 16'd5; b = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        drain(30);
        repeat (25) @(posedge clk);
        #1;
        chk("t3_one_done", dones - d0, 1);
        chk("t3_prod", prod, 63);

        // Start held through DONE accepts the next op back-to-back.
        @(posedge clk); #1;
        start = 1'b1; a = 16'd3; b = 16'd4;
        sb.push_back(model(16'd3, 16'd4, cyc + 1));
        n = 0;
        while (!done && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t4_first_done", done, 1);
        a = 16'd10; b = 16'd10;
        sb.push_back(model(16'd10, 16'd10, cyc + 1));
        @(posedge clk); #1;
        start = 1'b0;
        chk("t4_b2b_busy", busy, 1);
        drain(30);
        chk("t4_prod", prod, 100);

        // Reset mid-RUN aborts and clears the previous result.
        d0 = dones;
        issue(16'd1234, 16'd77);
        repeat (7) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        rst = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_prod", prod, 0);
        chk("t5_ovf", ovf, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("t5_no_done", dones - d0, 0);
        issue(16'd2, 16'd3);
        drain(30);
        chk("t5_prod_after", prod, 6);

        // Reset beats a simultaneous Start.
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1; a = 16'd9; b = 16'd9;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk("t6_busy", busy, 0);
        @(posedge clk); #1;
        chk("t6_busy_later", busy, 0);
        chk("t6_done", done, 0);

        // WIDTH=4: 15*15=225 -> low nibble 1, overflow; Done on the 4th edge after accept.
        @(posedge clk); #1;
        start4 = 1'b1; a4 = 4'd15; b4 = 4'd15;
        @(posedge clk); #1;
        start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
        chk("w4_busy", busy4, 1);
        n = 0;
        while (!done4 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w4_edges_to_done", n, 4);
        chk("w4_prod", prod4, 1);
        chk("w4_ovf", ovf4, 1);
        @(posedge clk); #1;
        chk("w4_done_off", done4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
